usb_reg_bridge: RTL
===================

// Module: usb_reg_bridge
// PURPOSE
//  Converts the asynchronous 8-bit USB-controller parallel bus (D/Addr/RDn/WRn/CEn/ALEn)
//  into the single-cycle register bus fanned out to reg_chipwhisperer, reg_clockglitch and others.
//  Sits between the top-level pads and the register slaves. Pad tristate stays outside.
//  Provides address latch, per-address byte counter, read/write strobes and read-data drive.
// PARAMETERS
//  SYNC_STAGES  2  flops in each control-strobe synchroniser (min 2)
//  READ_LAT     1  clk_usb cycles from reg_read_o pulse to reg_datai_i being valid (1..3)
//  ADDR_W       6  register address width taken from usb_addr_i[ADDR_W-1:0]
// PORTS
//  clk_usb          in   1   register-bus clock; all logic on rising edge
//  reset_i          in   1   asynchronous, active-high reset
//  usb_data_i       in   8   pad input side of USB_D
//  usb_data_o       out  8   read data to pad
//  usb_data_oe      out  1   1 = drive USB_D with usb_data_o
//  usb_addr_i       in   8   USB_Addr
//  usb_rdn_i        in   1   read strobe, active low
//  usb_wrn_i        in   1   write strobe, active low
//  usb_cen_i        in   1   chip enable, active low
//  usb_alen_i       in   1   address latch enable, active low
//  reg_address_o    out  6   latched register address
//  reg_bytecnt_o    out  16  byte index within current address
//  reg_datao_o      out  8   write data to slaves
//  reg_datai_i      in   8   OR-ed read data from slaves
//  reg_size_o       out  16  latched length of current register
//  reg_hyplen_i     in   16  OR-ed length for reg_hypaddress_o
//  reg_hypaddress_o out  6   synchronised live usb_addr_i[5:0] for length lookup
//  reg_read_o       out  1   1-cycle read strobe
//  reg_write_o      out  1   1-cycle write strobe
//  reg_addrvalid_o  out  1   address latched and CEn still low
//  err_count_o      out  8   protocol error count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; reg_size_o 0.
//  - rdn/wrn/cen/alen pass SYNC_STAGES flops. usb_addr_i/usb_data_i are registered alongside
//    (bus is stable across strobes). Edges are detected on the synchronised copies.
//  - FSM states:
//    - IDLE: on ALEn fall with CEn low -> ADDR.
//    - ADDR: latch address and reg_size_o <= reg_hyplen_i; bytecnt 0; addrvalid 1 -> READY.
//    - READY: WRn fall -> WR. RDn fall -> RD.
//    - WR: wait for WRn rise. Then reg_datao_o <= data, reg_write_o = 1 for one cycle,
//      bytecnt+1 the following cycle -> READY.
//    - RD: reg_read_o = 1 for one cycle. After READ_LAT cycles, usb_data_o <= reg_datai_i
//      -> RDHOLD.
//    - RDHOLD: wait for RDn rise, then bytecnt+1 -> READY.
//  - usb_data_oe = 1 from RD entry until RDn rise is seen; usb_data_o holds its value meanwhile.
//  - CEn rise in any state -> IDLE, addrvalid 0, oe 0. bytecnt and address hold their last value.
//  - New ALEn fall in READY re-latches the address and clears bytecnt.
//  - bytecnt wraps 0xFFFF -> 0x0000. It is not bounded by reg_size_o.
//  - RDn and WRn both low in the same cycle: protocol error; no strobe, stay READY.
//  - Strobe while in IDLE (no address latched): protocol error; ignored.
//  - Async reset mid-transfer: outputs clear immediately. Any pending strobe is lost.
// CONFIGURATION
//  - USB_REG_ERRCNT_EN defined: 8-bit saturating counter err_count_o, +1 per protocol error.
//    It clears only on reset_i.
//  - USB_REG_ERRCNT_EN undefined: err_count_o tied to 0; no counter logic.
// STRUCTURE
//  - Package usb_reg_pkg: state enum (IDLE, ADDR, READY, WR, RD, RDHOLD), ADDR_W/BYTECNT_W constants.
//  - Sub-module usb_strobe_sync: N-stage synchroniser plus rise/fall pulse outputs,
//    instantiated once per control strobe.
// TESTING
//  - ALEn pulse with addr 0x2A, CEn low, hyplen 4 -> reg_address_o 0x2A, reg_size_o 4,
//    addrvalid 1, bytecnt 0.
//  - 3 writes 0x11, 0x22, 0x33 -> three 1-cycle reg_write_o pulses with datao matching;
//    bytecnt 0, 1, 2 at the pulses, 3 after.
//  - Read, READ_LAT=2, slave returns 0xA5 -> reg_read_o 1 cycle, oe high until RDn rise,
//    usb_data_o 0xA5, bytecnt +1.
//  - bytecnt forced to 0xFFFF, one write -> bytecnt 0x0000, no other side effect.
//  - RDn and WRn low together, then WRn without ALEn after CEn rise -> no strobes;
//    err_count_o 2 with USB_REG_ERRCNT_EN, else 0.
//  - reset_i asserted mid-RD -> oe, reg_read_o, addrvalid 0 the same cycle; FSM IDLE.

Source files
------------

// File: rtl/usb_reg_pkg.sv
// Shared types and widths for the USB parallel-bus to register-bus bridge.
package usb_reg_pkg;

  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned BYTECNT_W = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LAT_W     = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    READY,
    WR,
    RD,
    RDHOLD
  } state_t;

endpackage

// File: rtl/usb_strobe_sync.sv
// N-stage synchroniser for one active-low bus strobe, with rise/fall pulses.
// The chain resets to the idle-high level so reset release never fakes an edge.
module usb_strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe_n,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= '1;
      prev_q  <= 1'b1;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], strobe_n};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign level  = chain_q[STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/usb_reg_bridge.sv
// Bridges the asynchronous 8-bit USB controller bus onto the single-cycle register bus.
// Optional protocol error counter enabled by defining USB_REG_ERRCNT_EN.
module usb_reg_bridge
  import usb_reg_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned ADDR_W      = usb_reg_pkg::ADDR_W
) (
  input  logic                 clk_usb,
  input  logic                 reset_i,
  input  logic [DATA_W-1:0]    usb_data_i,
  output logic [DATA_W-1:0]    usb_data_o,
  output logic                 usb_data_oe,
  input  logic [7:0]           usb_addr_i,
  input  logic                 usb_rdn_i,
  input  logic                 usb_wrn_i,
  input  logic                 usb_cen_i,
  input  logic                 usb_alen_i,
  output logic [ADDR_W-1:0]    reg_address_o,
  output logic [BYTECNT_W-1:0] reg_bytecnt_o,
  output logic [DATA_W-1:0]    reg_datao_o,
  input  logic [DATA_W-1:0]    reg_datai_i,
  output logic [BYTECNT_W-1:0] reg_size_o,
  input  logic [BYTECNT_W-1:0] reg_hyplen_i,
  output logic [ADDR_W-1:0]    reg_hypaddress_o,
  output logic                 reg_read_o,
  output logic                 reg_write_o,
  output logic                 reg_addrvalid_o,
  output logic [7:0]           err_count_o
);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [BYTECNT_W-1:0]  bytecnt_q;
  logic [LAT_W-1:0]      lat_q;

  logic rd_lvl, rd_rise_c, rd_fall_c;
  logic wr_lvl, wr_rise_c, wr_fall_c;
  logic cen_lvl, cen_rise_c, cen_fall_c;
  logic alen_lvl, alen_rise_c, alen_fall_c;

  logic latch_c, write_c, read_c, capture_c, rd_done_c, drop_c, both_c;

  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(clk_usb), .rst(reset_i), .strobe_n(usb_rdn_i),
    .level(rd_lvl), .rise_c(rd_rise_c), .fall_c(rd_fall_c)
  );
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk_usb), .rst(reset_i), .strobe_n(usb_wrn_i),
    .level(wr_lvl), .rise_c(wr_rise_c), .fall_c(wr_fall_c)
  );
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_cen_sync (
    .clk(clk_usb), .rst(reset_i), .strobe_n(usb_cen_i),
    .level(cen_lvl), .rise_c(cen_rise_c), .fall_c(cen_fall_c)
  );
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_alen_sync (
    .clk(clk_usb), .rst(reset_i), .strobe_n(usb_alen_i),
    .level(alen_lvl), .rise_c(alen_rise_c), .fall_c(alen_fall_c)
  );

  logic unused_sync;
  assign unused_sync = ^{rd_rise_c, cen_fall_c, alen_lvl, alen_rise_c};

  if (ADDR_W < 8) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^usb_addr_i[7:ADDR_W];
  end

  // Read and write both low while a strobe edge arrives is a collision, not a transfer
  assign both_c = (rd_fall_c || wr_fall_c) && !rd_lvl && !wr_lvl;
  assign drop_c = cen_rise_c && (state_q != IDLE);

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_c   = 1'b0;
    write_c   = 1'b0;
    read_c    = 1'b0;
    capture_c = 1'b0;
    rd_done_c = 1'b0;
    if (drop_c) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (alen_fall_c && !cen_lvl) state_d = ADDR;
        ADDR: begin
          latch_c = 1'b1;
          state_d = READY;
        end
        READY: begin
          if (alen_fall_c)    state_d = ADDR;
          else if (both_c)    state_d = READY;
          else if (wr_fall_c) state_d = WR;
          else if (rd_fall_c) begin
            read_c  = 1'b1;
            state_d = RD;
          end
        end
        WR: if (wr_rise_c) begin
          write_c = 1'b1;
          state_d = READY;
        end
        RD: if (lat_q == LAT_W'(READ_LAT)) begin
          capture_c = 1'b1;
          state_d   = RDHOLD;
        end
        // Level rather than edge so an early RDn release during RD is not missed
        RDHOLD: if (rd_lvl) begin
          rd_done_c = 1'b1;
          state_d   = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath registers steered by the FSM decode
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      addr_q           <= '0;
      data_q           <= '0;
      reg_hypaddress_o <= '0;
      reg_address_o    <= '0;
      reg_size_o       <= '0;
      bytecnt_q        <= '0;
      reg_datao_o      <= '0;
      reg_write_o      <= 1'b0;
      reg_read_o       <= 1'b0;
      reg_addrvalid_o  <= 1'b0;
      usb_data_o       <= '0;
      usb_data_oe      <= 1'b0;
      lat_q            <= '0;
    end else begin
      addr_q           <= usb_addr_i[ADDR_W-1:0];
      data_q           <= usb_data_i;
      reg_hypaddress_o <= addr_q;
      reg_write_o      <= write_c;
      reg_read_o       <= read_c;

      if (latch_c) begin
        reg_address_o   <= addr_q;
        reg_size_o      <= reg_hyplen_i;
        bytecnt_q       <= '0;
        reg_addrvalid_o <= 1'b1;
      end else if (reg_write_o || rd_done_c) begin
        bytecnt_q <= bytecnt_q + BYTECNT_W'(1);
      end
      if (drop_c) reg_addrvalid_o <= 1'b0;

      if (write_c)   reg_datao_o <= data_q;
      if (capture_c) usb_data_o  <= reg_datai_i;

      if (read_c)                   usb_data_oe <= 1'b1;
      else if (rd_done_c || drop_c) usb_data_oe <= 1'b0;

      if (read_c)              lat_q <= '0;
      else if (state_q == RD)  lat_q <= lat_q + LAT_W'(1);
    end
  end

  assign reg_bytecnt_o = bytecnt_q;

`ifdef USB_REG_ERRCNT_EN
  logic       err_c;
  logic [7:0] err_q;

  assign err_c = (state_q == IDLE && (rd_fall_c || wr_fall_c)) ||
                 (state_q == READY && !drop_c && !alen_fall_c && both_c);

  // Saturating protocol error counter, cleared only by reset
  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i)                    err_q <= '0;
    else if (err_c && err_q != '1)  err_q <= err_q + 8'(1);
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

endmodule
